// File: rtl/fifo_word_packer.sv
// Packs `ratio` consecutive show-ahead FIFO words into one wide valid/ready beat; flush emits a partial beat.
// Define WORD_PACKER_TIMEOUT_EN to auto-flush a partial beat after `timeout` idle cycles.
module fifo_word_packer #(
    parameter int width   = 8,
    parameter int ratio   = 4,
    parameter int timeout = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fifo_empty,
    input  logic [width-1:0]          fifo_read_data,
    output logic                      fifo_pop,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [width*ratio-1:0]    out_data,
    output logic [$clog2(ratio):0]    out_count
);
    localparam int CNTW = $clog2(ratio);
    localparam int CW   = CNTW + 1;

    if (ratio < 2 || timeout < 1) begin : g_param_check
        $error("fifo_word_packer: ratio must be >= 2 and timeout >= 1");
    end

    logic [ratio-1:0][width-1:0] acc;
    logic [ratio-1:0][width-1:0] acc_w;
    logic [ratio-1:0][width-1:0] data_r;
    logic [CNTW-1:0]             cnt;
    logic [CW-1:0]               eff_cnt;
    logic [CW-1:0]               count_r;
    logic                        valid_r;
    logic                        flush_pending;
    logic                        slot_free;
    logic                        last_lane;
    logic                        flush_req;
    logic                        complete;
    logic                        emit;
    logic                        auto_flush;

    // Handshake: a beat moves when out_valid & out_ready at a rising edge;
    // a FIFO word is consumed when fifo_pop & ~fifo_empty at a rising edge.
    assign slot_free = ~valid_r | out_ready;
    assign last_lane = (cnt == CNTW'(ratio - 1));
    assign fifo_pop  = ~rst & ~fifo_empty & ~(~slot_free & (last_lane | flush_pending));
    assign flush_req = flush | flush_pending | auto_flush;
    assign eff_cnt   = {1'b0, cnt} + CW'(fifo_pop);
    assign complete  = fifo_pop & last_lane;
    assign emit      = complete | (flush_req & slot_free & (eff_cnt != '0));

    // Accumulator view including the word being popped this cycle.
    always_comb begin
        acc_w = acc;
        if (fifo_pop) begin
            acc_w[cnt] = fifo_read_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc           <= '0;
            cnt           <= '0;
            data_r        <= '0;
            count_r       <= '0;
            valid_r       <= 1'b0;
            flush_pending <= 1'b0;
        end else begin
            if (emit) begin
                data_r  <= acc_w;
                count_r <= eff_cnt;
                valid_r <= 1'b1;
                acc     <= '0;
                cnt     <= '0;
            end else begin
                if (out_ready) begin
                    valid_r <= 1'b0;
                end
                acc <= acc_w;
                if (fifo_pop) begin
                    cnt <= cnt + CNTW'(1);
                end
            end
            // A flush is resolved (emitted or found empty) as soon as the slot is free.
            if (flush_req & slot_free) begin
                flush_pending <= 1'b0;
            end else if (flush_req) begin
                flush_pending <= 1'b1;
            end
        end
    end

`ifdef WORD_PACKER_TIMEOUT_EN
    localparam int IW = $clog2(timeout + 1);
    logic [IW-1:0] idle_cnt;

    assign auto_flush = (idle_cnt == IW'(timeout));

    // Saturates at timeout so the internal flush holds while the slot is busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (fifo_pop | emit) begin
            idle_cnt <= '0;
        end else if ((cnt != '0) && !auto_flush) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end
`else
    assign auto_flush = 1'b0;
`endif

    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign out_count = count_r;
endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: queue-level model checked every cycle plus literal beat expectations.
module tb_fifo_word_packer;
    localparam int W  = 8;
    localparam int R  = 4;
    localparam int CW = $clog2(R) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            fifo_empty;
    logic [W-1:0]    fifo_read_data;
    logic            fifo_pop;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [W*R-1:0]  out_data;
    logic [CW-1:0]   out_count;

    fifo_word_packer #(.width(W), .ratio(R), .timeout(16)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
        .fifo_pop(fifo_pop), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0]   fifo_q[$];
    logic [W*R-1:0] exp_dq[$];
    logic [CW-1:0]  exp_cq[$];

    logic           pop_seen = 1'b0;
    int             run = 0;
    int             max_run = 0;

    // Model state: words held so far, the output slot, and the pending flush.
    logic [W-1:0]   m_words[$];
    logic [W-1:0]   eff[$];
    logic           m_valid = 1'b0;
    logic [W*R-1:0] m_data = '0;
    int             m_count = 0;
    logic           m_pend = 1'b0;
    int             m_idle = 0;
    logic           sf, tf, freq, blk, mp, em, had_words;
    int             n;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic refresh();
        fifo_empty     = (fifo_q.size() == 0);
        fifo_read_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic push(input logic [W-1:0] w);
        fifo_q.push_back(w);
        refresh();
    endtask

    task automatic expect_beat(input logic [W*R-1:0] d, input logic [CW-1:0] c);
        exp_dq.push_back(d);
        exp_cq.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_seen && fifo_q.size() != 0) void'(fifo_q.pop_front());
        run = pop_seen ? run + 1 : 0;
        if (run > max_run) max_run = run;
        flush = 1'b0;
        refresh();
    endtask

    task automatic drain(input string name, input int budget);
        while (budget > 0 && (exp_dq.size() != 0 || fifo_q.size() != 0)) begin
            tick();
            budget--;
        end
        check(name, exp_dq.size(), 0);
        repeat (2) tick();
    endtask

    // Compare process: outputs settled since the last rising edge are checked at the falling edge.
    always @(negedge clk) begin
        pop_seen = fifo_pop;
        if (rst) begin
            check("rst_valid", out_valid, 0);
            check("rst_count", out_count, 0);
            check("rst_pop", fifo_pop, 0);
            m_words.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_count = 0;
            m_pend  = 1'b0;
            m_idle  = 0;
        end else begin
            check("valid", out_valid, m_valid);
            if (m_valid) begin
                check("data", out_data, m_data);
                check("count", out_count, m_count);
            end
            sf = !m_valid || out_ready;
            tf = 1'b0;
`ifdef WORD_PACKER_TIMEOUT_EN
            tf = (m_idle == 16);
`endif
            freq = flush || m_pend || tf;
            blk  = !sf && (m_words.size() == R - 1 || m_pend);
            mp   = (fifo_q.size() != 0) && !blk;
            check("pop", fifo_pop, mp);
            if (out_valid && out_ready) begin
                if (exp_dq.size() == 0) begin
                    check("unexpected_beat", out_data, '0);
                    check("unexpected_beat_valid", out_valid, 0);
                end else begin
                    check("sb_data", out_data, exp_dq.pop_front());
                    check("sb_count", out_count, exp_cq.pop_front());
                end
            end
            had_words = (m_words.size() != 0);
            eff = m_words;
            if (mp) eff.push_back(fifo_q[0]);
            n  = eff.size();
            em = (n == R) || (freq && sf && n > 0);
            if (em) begin
                m_data = '0;
                for (int i = 0; i < n; i++) m_data[i*W +: W] = eff[i];
                m_count = n;
                m_valid = 1'b1;
                m_words.delete();
            end else begin
                if (out_ready) m_valid = 1'b0;
                m_words = eff;
            end
            if (freq && sf) m_pend = 1'b0;
            else if (freq) m_pend = 1'b1;
            if (mp || em) m_idle = 0;
            else if (had_words && m_idle < 16) m_idle++;
        end
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        refresh();
        repeat (3) tick();
        rst = 1'b0;
        check("reset_valid", out_valid, 0);
        check("reset_count", out_count, 0);
        check("reset_data", out_data, 0);

        // Single full beat.
        max_run = 0;
        expect_beat(32'h44332211, 4);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        drain("single_beat", 20);
        check("single_pop_run", max_run, 4);

        // Two back-to-back beats with continuous pops.
        max_run = 0;
        expect_beat(32'h04030201, 4);
        expect_beat(32'h08070605, 4);
        for (int i = 1; i <= 8; i++) push(W'(i));
        drain("b2b", 30);
        check("b2b_pop_run", max_run, 8);

        // Downstream stall after the first beat.
        out_ready = 1'b0;
        expect_beat(32'h04030201, 4);
        expect_beat(32'h08070605, 4);
        for (int i = 1; i <= 8; i++) push(W'(i));
        repeat (12) tick();
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, 32'h04030201);
        check("stall_fifo_left", fifo_q.size(), 1);
        check("stall_no_pop", fifo_pop, 0);
        out_ready = 1'b1;
        drain("stall_release", 20);

        // Partial beat via flush, then a flush with nothing held.
        expect_beat(32'h0000BBAA, 2);
        push(8'hAA); push(8'hBB);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        drain("flush_partial", 20);
        flush = 1'b1;
        tick();
        repeat (3) tick();
        check("flush_empty_no_beat", out_valid, 0);

        // Flush while a full beat is stalled and one word is held.
        out_ready = 1'b0;
        expect_beat(32'h54535251, 4);
        expect_beat(32'h00000055, 1);
        push(8'h51); push(8'h52); push(8'h53); push(8'h54); push(8'h55);
        repeat (8) tick();
        flush = 1'b1;
        tick();
        repeat (3) tick();
        check("pend_held_count", out_count, 4);
        check("pend_fifo_drained", fifo_q.size(), 0);
        out_ready = 1'b1;
        drain("pend_release", 20);

        // Reset mid-accumulation.
        push(8'h61); push(8'h62);
        repeat (4) tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", out_count, 0);
        fifo_q.delete();
        refresh();
        expect_beat(32'h74737271, 4);
        push(8'h71); push(8'h72); push(8'h73); push(8'h74);
        drain("post_rst_beat", 20);

        // Reset while a beat is stalled.
        out_ready = 1'b0;
        push(8'h81); push(8'h82); push(8'h83); push(8'h84);
        repeat (6) tick();
        check("stall_before_rst", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("stall_rst_valid", out_valid, 0);
        out_ready = 1'b1;
        fifo_q.delete();
        refresh();
        expect_beat(32'h94939291, 4);
        push(8'h91); push(8'h92); push(8'h93); push(8'h94);
        drain("post_stall_rst", 20);

`ifdef WORD_PACKER_TIMEOUT_EN
        // Idle timeout emits a one-word partial beat.
        expect_beat(32'h000000A5, 1);
        push(8'hA5);
        drain("timeout_flush", 60);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
